// File: rtl/ssd1309_pkg.sv
// Shared SSD1309 definitions: command opcodes and the
// frame-streamer state encoding.
package ssd1309_pkg;

    localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
    localparam int         CMD_SEQ_LEN   = 6;

    typedef logic [2:0] cmd_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        FETCH,
        WAIT,
        SEND,
        DONE
    } stream_state_t;

endpackage

// File: rtl/oled_cmd_rom.sv
// Address-window command preamble sent before every frame:
// full column range, then full page range.
module oled_cmd_rom
    import ssd1309_pkg::*;
#(
    parameter int FB_WIDTH = 128,
    parameter int FB_PAGES = 8
) (
    input  cmd_idx_t   idx,
    output logic [7:0] data
);

    always_comb begin
        data = 8'h00;
        case (idx)
            3'd0:    data = CMD_COL_ADDR;
            3'd1:    data = 8'h00;
            3'd2:    data = 8'(FB_WIDTH - 1);
            3'd3:    data = CMD_PAGE_ADDR;
            3'd4:    data = 8'h00;
            3'd5:    data = 8'(FB_PAGES - 1);
            default: data = 8'h00;
        endcase
    end

endmodule

// File: rtl/oled_frame_streamer.sv
// Streams a monochrome framebuffer to the SSD1309 byte driver:
// address-window commands, then page-major column data.
module oled_frame_streamer
    import ssd1309_pkg::*;
#(
    parameter int FB_WIDTH = 128,
    parameter int FB_PAGES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       auto_refresh,
    output logic       busy,
    output logic       frame_done,
    output logic       fb_re,
    output logic [7:0] fb_r_xpos,
    output logic [7:0] fb_r_ypos,
    output logic       fb_r_mode,
    input  logic [7:0] fb_dout,
    output logic [7:0] tx_data,
    output logic       tx_dc,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int CW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
    localparam int PW = (FB_PAGES > 1) ? $clog2(FB_PAGES) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(FB_WIDTH - 1);
    localparam logic [PW-1:0] PAGE_LAST = PW'(FB_PAGES - 1);
    localparam cmd_idx_t      CMD_LAST  = cmd_idx_t'(CMD_SEQ_LEN - 1);

    stream_state_t state;
    stream_state_t state_next;

    logic [CW-1:0] col;
    logic [PW-1:0] page;
    cmd_idx_t      cmd_idx;
    logic [7:0]    data_q;
    logic [7:0]    rom_byte;
    logic          col_last;
    logic          page_last;

    assign col_last  = (col == COL_LAST);
    assign page_last = (page == PAGE_LAST);

    oled_cmd_rom #(
        .FB_WIDTH(FB_WIDTH),
        .FB_PAGES(FB_PAGES)
    ) u_cmd_rom (
        .idx  (cmd_idx),
        .data (rom_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        frame_done = 1'b0;
        fb_re      = 1'b0;
        tx_valid   = 1'b0;
        tx_dc      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = CMD;
                end
            end
            CMD: begin
                tx_valid = 1'b1;
                if (tx_ready && cmd_idx == CMD_LAST) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                fb_re      = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                state_next = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_dc    = 1'b1;
                if (tx_ready) begin
                    state_next = (col_last && page_last) ? DONE : FETCH;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = auto_refresh ? CMD : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counters wrap on the last data byte so they never leave range.
    always_ff @(posedge clk) begin
        if (reset) begin
            col     <= '0;
            page    <= '0;
            cmd_idx <= '0;
            data_q  <= 8'h00;
        end else begin
            if (state == CMD) begin
                col  <= '0;
                page <= '0;
                if (tx_ready) begin
                    cmd_idx <= (cmd_idx == CMD_LAST) ? '0 : cmd_idx + 3'd1;
                end
            end
            if (state == WAIT) begin
                data_q <= fb_dout;
            end
            if (state == SEND && tx_ready) begin
                if (col_last) begin
                    col  <= '0;
                    page <= page_last ? '0 : page + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign tx_data   = (state == CMD) ? rom_byte : data_q;
    assign fb_r_xpos = 8'(col);
    assign fb_r_ypos = 8'({page, 3'b000});
    assign fb_r_mode = 1'b1;

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Self-checking bench for oled_frame_streamer: a stream-level model
// of the expected byte sequence plus directed frame scenarios.
module tb_oled_frame_streamer;

    localparam int W     = 128;
    localparam int P     = 8;
    localparam int NB    = W * P;
    localparam int FRAME = 6 + NB;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       auto_refresh;
    logic       busy;
    logic       frame_done;
    logic       fb_re;
    logic [7:0] fb_r_xpos;
    logic [7:0] fb_r_ypos;
    logic       fb_r_mode;
    logic [7:0] fb_dout;
    logic [7:0] tx_data;
    logic       tx_dc;
    logic       tx_valid;
    logic       tx_ready;

    int checks   = 0;
    int errors   = 0;
    int pct      = 100;
    int hs_n     = 0;
    int rd_n     = 0;
    int done_cnt = 0;
    int hs_total = 0;
    int busy_cyc = 0;

    logic       capture    = 1'b0;
    logic       prev_stall = 1'b0;
    logic       prev_done  = 1'b0;
    logic       prev_auto  = 1'b0;
    logic [8:0] prev_out   = 9'h0;
    logic [7:0] cap [0:FRAME-1];

    always #5 clk = ~clk;

    oled_frame_streamer #(
        .FB_WIDTH(W),
        .FB_PAGES(P)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .auto_refresh (auto_refresh),
        .busy         (busy),
        .frame_done   (frame_done),
        .fb_re        (fb_re),
        .fb_r_xpos    (fb_r_xpos),
        .fb_r_ypos    (fb_r_ypos),
        .fb_r_mode    (fb_r_mode),
        .fb_dout      (fb_dout),
        .tx_data      (tx_data),
        .tx_dc        (tx_dc),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    function automatic logic [7:0] fb_byte(input int c, input int p);
        return 8'(c ^ p);
    endfunction

    // {dc, data} of the n-th accepted byte of a frame.
    function automatic logic [8:0] exp_byte(input int n);
        case (n)
            0:       return {1'b0, 8'h21};
            1:       return {1'b0, 8'h00};
            2:       return {1'b0, 8'(W - 1)};
            3:       return {1'b0, 8'h22};
            4:       return {1'b0, 8'h00};
            5:       return {1'b0, 8'(P - 1)};
            default: return {1'b1, fb_byte((n - 6) % W, (n - 6) / W)};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (fb_re) begin
            fb_dout <= fb_byte(int'(fb_r_xpos), int'(fb_r_ypos) / 8);
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2 tx_ready = ($urandom_range(0, 99) < pct);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            hs_n       = 0;
            rd_n       = 0;
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            chk("fb_mode", 32'(fb_r_mode), 32'd1);
            if (prev_stall) begin
                chk("stall_hold", 32'({tx_valid, tx_dc, tx_data}),
                    32'({1'b1, prev_out}));
            end
            if (prev_done) begin
                if (prev_auto) begin
                    chk("restart_cmd", 32'({tx_valid, tx_dc, tx_data}),
                        32'({1'b1, 1'b0, 8'h21}));
                end else begin
                    chk("idle_after_done", 32'({busy, tx_valid}), 32'd0);
                end
            end
            if (busy) busy_cyc++;
            if (fb_re) begin
                chk("fb_addr", 32'({fb_r_xpos, fb_r_ypos}),
                    32'({8'(rd_n % W), 8'((rd_n / W) * 8)}));
                chk("re_vs_valid", 32'(tx_valid), 32'd0);
                rd_n++;
            end
            if (tx_valid && tx_ready) begin
                if (hs_n < FRAME) begin
                    chk("byte", 32'({tx_dc, tx_data}), 32'(exp_byte(hs_n)));
                    if (capture) cap[hs_n] = tx_data;
                end else begin
                    chk("extra_byte", 32'(hs_n), 32'(FRAME - 1));
                end
                hs_n++;
                hs_total++;
            end
            if (frame_done) begin
                chk("frame_len", 32'(hs_n), 32'(FRAME));
                chk("frame_reads", 32'(rd_n), 32'(NB));
                done_cnt++;
                hs_n = 0;
                rd_n = 0;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_out   = {tx_dc, tx_data};
            prev_done  = frame_done;
            prev_auto  = auto_refresh;
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_done(input int max, input string name);
        bit got = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (frame_done) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_hs(input int target, input int max, input string name);
        bit got = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            #1;
            if (hs_n >= target) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_reach"}, 32'(got), 32'd1);
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_ctl"}, 32'({busy, frame_done, fb_re, tx_valid, tx_dc}),
            32'd0);
        chk({name, "_data"}, 32'(tx_data), 32'd0);
        chk({name, "_pos"}, 32'({fb_r_xpos, fb_r_ypos}), 32'd0);
        chk({name, "_mode"}, 32'(fb_r_mode), 32'd1);
    endtask

    initial begin
        int d0;
        int h0;
        reset        = 1'b1;
        start        = 1'b0;
        auto_refresh = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outs("reset");
        @(posedge clk);
        #2 reset = 1'b0;

        // Best case: ready always high, full frame captured.
        capture  = 1'b1;
        busy_cyc = 0;
        pulse_start();
        wait_done(5000, "t1");
        capture = 1'b0;
        chk("t1_busy_cycles", 32'(busy_cyc), 32'd3079);
        chk("t1_cmd0", 32'(cap[0]), 32'h21);
        chk("t1_cmd1", 32'(cap[1]), 32'h00);
        chk("t1_cmd2", 32'(cap[2]), 32'h7F);
        chk("t1_cmd3", 32'(cap[3]), 32'h22);
        chk("t1_cmd4", 32'(cap[4]), 32'h00);
        chk("t1_cmd5", 32'(cap[5]), 32'h07);
        chk("t1_data_first", 32'(cap[6]), 32'h00);
        chk("t1_data_c2p1", 32'(cap[6 + 130]), 32'h03);
        chk("t1_data_c9p5", 32'(cap[6 + 5 * 128 + 9]), 32'h0C);
        chk("t1_data_last", 32'(cap[6 + 1023]), 32'h78);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        // Throttled ready.
        pct = 30;
        pulse_start();
        wait_done(20000, "t2");
        pct = 100;
        chk("t2_done_cnt", 32'(done_cnt), 32'd2);

        // Start while busy must be ignored.
        pulse_start();
        wait_hs(506, 10000, "t3");
        pulse_start();
        wait_done(5000, "t3");
        repeat (40) @(negedge clk);
        #1;
        chk("t3_done_cnt", 32'(done_cnt), 32'd3);
        chk("t3_idle", 32'(busy), 32'd0);

        // Mid-frame reset aborts without frame_done.
        pulse_start();
        wait_hs(306, 10000, "t4");
        d0 = done_cnt;
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1 chk_reset_outs("t4_reset");
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("t4_no_done", 32'(done_cnt), 32'(d0));
        chk("t4_idle", 32'(busy), 32'd0);
        capture = 1'b1;
        pulse_start();
        wait_done(5000, "t4");
        capture = 1'b0;
        chk("t4_first_byte", 32'(cap[0]), 32'h21);
        chk("t4_done_cnt", 32'(done_cnt), 32'(d0 + 1));

        // Auto refresh across two frames.
        h0           = hs_total;
        d0           = done_cnt;
        auto_refresh = 1'b1;
        pulse_start();
        wait_done(5000, "t5a");
        @(posedge clk);
        #2 auto_refresh = 1'b0;
        wait_done(5000, "t5b");
        chk("t5_handshakes", 32'(hs_total - h0), 32'(2 * FRAME));
        chk("t5_done_cnt", 32'(done_cnt), 32'(d0 + 2));
        chk("t5_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
